// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// controller states and the per-operation iteration count.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request / result bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] WData;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WData,
    input  Hi, Lo, Busy, Done
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WData,
    output Hi, Lo, Busy, Done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers; one bit
// per cycle on a shared 64-bit accumulator, fixed 34-cycle occupancy.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input logic            Clk,
  input logic            Rst,
  mult_div_unit_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opnd_q, opnd_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        signed_req, div_req;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff, div_rem;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Datapath: request magnitudes, one iteration step, and sign fix-up.
  always_comb begin
    signed_req = op_is_signed(op_e'(bus.Op));
    div_req    = op_is_div(op_e'(bus.Op));
    mag_a      = (signed_req && bus.OperandA[31]) ? -bus.OperandA : bus.OperandA;
    mag_b      = (signed_req && bus.OperandB[31]) ? -bus.OperandB : bus.OperandB;

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[31:0] - opnd_q;
    div_rem   = div_ge ? div_diff : div_shift[31:0];

    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    // A zero divisor leaves the dividend magnitude as remainder, so the
    // dividend-sign rule below restores the original OperandA.
    if (opnd_q == 32'd0)
      quo_fix = 32'hFFFF_FFFF;
    else
      quo_fix = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
    rem_fix = neg_a_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.HiWrite) hi_d = bus.WData;
        if (bus.LoWrite) lo_d = bus.WData;
        if (bus.Start) begin
          op_d    = op_e'(bus.Op);
          neg_a_d = signed_req & bus.OperandA[31];
          neg_b_d = signed_req & bus.OperandB[31];
          acc_d   = {32'd0, div_req ? mag_a : mag_b};
          opnd_d  = div_req ? mag_b : mag_a;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (op_is_div(op_q))
          acc_d = {div_rem, acc_q[30:0], div_ge};
        else
          acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = (state_q == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random ops
// against an arithmetic reference, and hand-written timing/corner sequences.
module tb_mult_div_unit;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Issue one op from IDLE and check latency, Busy framing and result.
  task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    logic busy0;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.OperandA = a;
    bus.OperandB = b;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    lat = -1;
    busy0 = 1'b0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge Clk);
      if (k == 0) busy0 = bus.Busy;
      if (bus.Done) lat = k;
    end
    check({name, "_busy0"}, 64'(busy0), 64'd1);
    check({name, "_lat"}, 64'(lat), 64'd33);
    check({name, "_hilo"}, {bus.Hi, bus.Lo}, {exp_hi, exp_lo});
    @(negedge Clk);
    check({name, "_idle"}, {62'd0, bus.Busy, bus.Done}, 64'd0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, bus.Hi, bus.Lo, lat);
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] hi_before, lo_before;
    int          pulses, done_at0, done_at1;
    logic        busy34;

    Rst = 1'b1;
    bus.Start = 1'b0;
    bus.Op = 2'b00;
    bus.OperandA = '0;
    bus.OperandB = '0;
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    bus.WData = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    check("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);

    tbl[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{2'b11, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
    tbl[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    tbl[6]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[8]  = '{2'b11, 32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF};
    tbl[9]  = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    tbl[10] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    for (int i = 0; i < 11; i++)
      check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) ra = -ra;
      exp = model(rop, ra, rb);
      check_op($sformatf("rnd%0d", i), rop, ra, rb, exp[63:32], exp[31:0]);
    end

    // MTHI/MTLO in idle, then ignored while busy.
    @(negedge Clk);
    bus.HiWrite = 1'b1;
    bus.LoWrite = 1'b1;
    bus.WData = 32'hCAFE_F00D;
    @(posedge Clk);
    #1 bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    @(negedge Clk);
    check("mt_idle", {bus.Hi, bus.Lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    bus.Start = 1'b1;
    bus.Op = 2'b01;
    bus.OperandA = 32'd2;
    bus.OperandB = 32'd3;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    bus.HiWrite = 1'b1;
    bus.LoWrite = 1'b1;
    bus.WData = 32'h1234_5678;
    repeat (10) @(negedge Clk);
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
    check("mt_busy_ignored", {bus.Hi, bus.Lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    pulses = 0;
    for (int k = 0; k < 40 && pulses == 0; k++) begin
      @(negedge Clk);
      if (bus.Done) pulses++;
    end
    check("mt_op_result", {bus.Hi, bus.Lo}, {32'd0, 32'd6});
    @(negedge Clk);
    bus.HiWrite = 1'b1;
    bus.WData = 32'h1234_5678;
    @(posedge Clk);
    #1 bus.HiWrite = 1'b0;
    @(negedge Clk);
    check("mthi_idle", {bus.Hi, bus.Lo}, {32'h1234_5678, 32'd6});

    // Start coinciding with MTHI: write lands, op still accepted.
    bus.Start = 1'b1;
    bus.HiWrite = 1'b1;
    bus.WData = 32'h5555_5555;
    bus.Op = 2'b00;
    bus.OperandA = 32'hFFFF_FFFD;
    bus.OperandB = 32'd7;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    bus.HiWrite = 1'b0;
    @(negedge Clk);
    check("coincide_write", {31'd0, bus.Busy, bus.Hi}, {31'd1, 32'h5555_5555});
    pulses = 0;
    for (int k = 0; k < 40 && pulses == 0; k++) begin
      @(negedge Clk);
      if (bus.Done) pulses++;
    end
    check("coincide_result", {bus.Hi, bus.Lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(negedge Clk);

    // Reset while counter=15: op abandoned, no Done.
    hi_before = bus.Hi;
    lo_before = bus.Lo;
    check("pre_rst_nonzero", 64'({hi_before, lo_before} != 64'd0), 64'd1);
    bus.Start = 1'b1;
    bus.Op = 2'b01;
    bus.OperandA = 32'd5;
    bus.OperandB = 32'd9;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (15) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("midrst_state", {bus.Hi, bus.Lo}, 64'd0);
    check("midrst_busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (bus.Done || bus.Busy) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);

    // Start held high: one op per 35-cycle window.
    bus.Start = 1'b1;
    bus.Op = 2'b00;
    bus.OperandA = 32'hFFFF_FFFD;
    bus.OperandB = 32'd7;
    @(posedge Clk);
    pulses = 0;
    done_at0 = -1;
    done_at1 = -1;
    busy34 = 1'b1;
    for (int k = 0; k < 70; k++) begin
      @(negedge Clk);
      if (bus.Done) begin
        if (pulses == 0) done_at0 = k;
        if (pulses == 1) done_at1 = k;
        pulses++;
      end
      if (k == 34) busy34 = bus.Busy;
      if (k == 69) bus.Start = 1'b0;
    end
    check("held_pulses", 64'(pulses), 64'd2);
    check("held_done0", 64'(done_at0), 64'd33);
    check("held_done1", 64'(done_at1), 64'd68);
    check("held_gap_idle", 64'(busy34), 64'd0);
    check("held_result", {bus.Hi, bus.Lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    repeat (3) @(negedge Clk);
    check("held_final_idle", {62'd0, bus.Busy, bus.Done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
